ycr1_wbb_arb: RTL and testbench

Single-clock, parametrised N-master to 1-slave Wishbone burst arbiter using the team's burst extension (bl, bry, lack). It sits between the core-side ports (instruction, data, DMA) and the wishbone bridge / internal slave fabric. Compared with the existing bridge path, it adds:
- per-master arbitration, round-robin or fixed priority;
- grant locking across whole bursts;
- real error propagation;
- a transaction timeout.

---
 rtl/ycr1_wbb_arb.sv | 162 ++++++++++++++++
 tb/tb_ycr1_wbb_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_wbb_arb.sv
// N-master to 1-slave Wishbone burst arbiter: round-robin or fixed priority, grant held for a whole burst, slave timeout.
// Latency: a request seen in IDLE raises slave stb the next cycle; ack/lack/err/data return combinationally.
// Backpressure: other masters wait until the granted burst ends (lack, err, abort or timeout) plus one gap cycle.

module ycr1_wbb_arb #(
    parameter int NM       = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int BW       = 4,
    parameter int BL       = 10,
    parameter int ARB_MODE = 0,
    parameter int TOUT     = 1023
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic [NM-1:0]       wbm_cyc_i,
    input  logic [NM-1:0]       wbm_stb_i,
    input  logic [NM*AW-1:0]    wbm_adr_i,
    input  logic [NM-1:0]       wbm_we_i,
    input  logic [NM*DW-1:0]    wbm_dat_i,
    input  logic [NM*BW-1:0]    wbm_sel_i,
    input  logic [NM*BL-1:0]    wbm_bl_i,
    input  logic [NM-1:0]       wbm_bry_i,
    output logic [DW-1:0]       wbm_dat_o,
    output logic [NM-1:0]       wbm_ack_o,
    output logic [NM-1:0]       wbm_lack_o,
    output logic [NM-1:0]       wbm_err_o,
    output logic                wbs_cyc_o,
    output logic                wbs_stb_o,
    output logic [AW-1:0]       wbs_adr_o,
    output logic                wbs_we_o,
    output logic [DW-1:0]       wbs_dat_o,
    output logic [BW-1:0]       wbs_sel_o,
    output logic [BL-1:0]       wbs_bl_o,
    output logic                wbs_bry_o,
    input  logic [DW-1:0]       wbs_dat_i,
    input  logic                wbs_ack_i,
    input  logic                wbs_lack_i,
    input  logic                wbs_err_i
);

    localparam int GW = $clog2(NM);
    // Counter only needs to reach TOUT-1; the timeout fires there and the burst ends.
    localparam int TW = (TOUT > 2) ? $clog2(TOUT) : 1;
    localparam logic [TW-1:0] TOUT_LAST = TW'((TOUT > 0) ? TOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NM-1:0]   r_gnt;
    logic [GW-1:0]   r_gnt_idx;
    logic [GW-1:0]   r_last_gnt;
    logic [TW-1:0]   r_tout_cnt;

    logic [NM-1:0]   w_req;
    logic [GW:0]     w_cand;
    logic            w_win_vld;
    logic [GW-1:0]   w_win_idx;
    logic [NM-1:0]   w_win_oh;
    logic            w_busy;
    logic            w_gnt_cyc;
    logic            w_tout_fire;
    logic            w_exit;
    logic [BL-1:0]   w_bl;

    assign w_req = wbm_cyc_i & wbm_stb_i;

    // Pick the winner: lowest index in fixed priority, else first requester after last_gnt (wrapping).
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_win_oh  = '0;
        w_cand    = '0;
        for (int k = 0; k < NM; k++) begin
            if (ARB_MODE == 1) begin
                w_cand = (GW+1)'(k);
            end else begin
                w_cand = {1'b0, r_last_gnt} + (GW+1)'(k + 1);
                if (w_cand >= (GW+1)'(NM)) begin
                    w_cand = w_cand - (GW+1)'(NM);
                end
            end
            if (!w_win_vld && w_req[w_cand[GW-1:0]]) begin
                w_win_vld              = 1'b1;
                w_win_idx              = w_cand[GW-1:0];
                w_win_oh[w_cand[GW-1:0]] = 1'b1;
            end
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_gnt_cyc = wbm_cyc_i[r_gnt_idx];

    // Timeout has the lowest exit priority: any slave response or a master abort wins over it.
    assign w_tout_fire = (TOUT != 0) && w_busy && (r_tout_cnt == TOUT_LAST) &&
                         !wbs_ack_i && !wbs_err_i && !wbs_lack_i && w_gnt_cyc;

    assign w_exit = w_busy && (wbs_err_i || wbs_lack_i || !w_gnt_cyc || w_tout_fire);

    // Next-state: one grant per burst, always a single gap cycle before re-arbitrating.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_win_vld) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_exit)    w_state_nxt = ST_GAP;
            ST_GAP:                 w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant capture, round-robin pointer update on burst end, and the quiet-cycle counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last_gnt <= GW'(NM - 1);
            r_tout_cnt <= '0;
        end else if (r_state == ST_IDLE && w_win_vld) begin
            r_gnt      <= w_win_oh;
            r_gnt_idx  <= w_win_idx;
            r_tout_cnt <= '0;
        end else if (w_busy) begin
            if (w_exit) begin
                r_gnt      <= '0;
                r_last_gnt <= r_gnt_idx;
            end
            r_tout_cnt <= wbs_ack_i ? '0 : r_tout_cnt + 1'b1;
        end
    end

    // Slave side: driven from the granted master only while BUSY; an abort drops cyc the same cycle.
    assign wbs_cyc_o = w_busy & w_gnt_cyc;
    assign wbs_stb_o = w_busy & w_gnt_cyc;
    assign wbs_bry_o = w_busy & w_gnt_cyc & wbm_bry_i[r_gnt_idx];
    assign wbs_adr_o = wbm_adr_i[int'(r_gnt_idx)*AW +: AW];
    assign wbs_we_o  = wbm_we_i[r_gnt_idx];
    assign wbs_dat_o = wbm_dat_i[int'(r_gnt_idx)*DW +: DW];
    assign wbs_sel_o = wbm_sel_i[int'(r_gnt_idx)*BW +: BW];
    assign w_bl      = wbm_bl_i[int'(r_gnt_idx)*BL +: BL];
    assign wbs_bl_o  = (w_bl == '0) ? BL'(1) : w_bl;

    // Master side: responses reach only the granted master; an error closes the burst and hides any ack.
    assign wbm_dat_o  = wbs_dat_i;
    assign wbm_ack_o  = {NM{w_busy & wbs_ack_i & ~wbs_err_i}} & r_gnt;
    assign wbm_lack_o = {NM{w_busy & (wbs_lack_i | wbs_err_i | w_tout_fire)}} & r_gnt;
    assign wbm_err_o  = {NM{w_busy & (wbs_err_i | w_tout_fire)}} & r_gnt;

endmodule

// File: tb/tb_ycr1_wbb_arb.sv
// Bench for ycr1_wbb_arb: one round-robin and one fixed-priority instance, both with TOUT=16.
// Table vectors and directed sequences for the burst corner cases, then random traffic against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_ycr1_wbb_arb;

    localparam int NM = 3, AW = 32, DW = 32, BW = 4, BL = 10, TOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Per-instance stimulus (0 = round-robin, 1 = fixed priority)
    logic [NM-1:0]    m_cyc [2];
    logic [NM-1:0]    m_stb [2];
    logic [NM-1:0]    m_we  [2];
    logic [NM-1:0]    m_bry [2];
    logic [NM*AW-1:0] m_adr [2];
    logic [NM*DW-1:0] m_dat [2];
    logic [NM*BW-1:0] m_sel [2];
    logic [NM*BL-1:0] m_bl  [2];
    logic [DW-1:0]    s_dat [2];
    logic             s_ack [2];
    logic             s_lack[2];
    logic             s_err [2];

    logic [DW-1:0]    o_mdat[2];
    logic [NM-1:0]    o_ack [2];
    logic [NM-1:0]    o_lack[2];
    logic [NM-1:0]    o_err [2];
    logic             o_cyc [2];
    logic             o_stb [2];
    logic             o_we  [2];
    logic             o_bry [2];
    logic [AW-1:0]    o_adr [2];
    logic [DW-1:0]    o_sdat[2];
    logic [BW-1:0]    o_sel [2];
    logic [BL-1:0]    o_bl  [2];

    ycr1_wbb_arb #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL), .ARB_MODE(0), .TOUT(TOUT)) u_rr (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbm_cyc_i(m_cyc[0]), .wbm_stb_i(m_stb[0]), .wbm_adr_i(m_adr[0]), .wbm_we_i(m_we[0]),
        .wbm_dat_i(m_dat[0]), .wbm_sel_i(m_sel[0]), .wbm_bl_i(m_bl[0]), .wbm_bry_i(m_bry[0]),
        .wbm_dat_o(o_mdat[0]), .wbm_ack_o(o_ack[0]), .wbm_lack_o(o_lack[0]), .wbm_err_o(o_err[0]),
        .wbs_cyc_o(o_cyc[0]), .wbs_stb_o(o_stb[0]), .wbs_adr_o(o_adr[0]), .wbs_we_o(o_we[0]),
        .wbs_dat_o(o_sdat[0]), .wbs_sel_o(o_sel[0]), .wbs_bl_o(o_bl[0]), .wbs_bry_o(o_bry[0]),
        .wbs_dat_i(s_dat[0]), .wbs_ack_i(s_ack[0]), .wbs_lack_i(s_lack[0]), .wbs_err_i(s_err[0])
    );

    ycr1_wbb_arb #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL), .ARB_MODE(1), .TOUT(TOUT)) u_fp (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbm_cyc_i(m_cyc[1]), .wbm_stb_i(m_stb[1]), .wbm_adr_i(m_adr[1]), .wbm_we_i(m_we[1]),
        .wbm_dat_i(m_dat[1]), .wbm_sel_i(m_sel[1]), .wbm_bl_i(m_bl[1]), .wbm_bry_i(m_bry[1]),
        .wbm_dat_o(o_mdat[1]), .wbm_ack_o(o_ack[1]), .wbm_lack_o(o_lack[1]), .wbm_err_o(o_err[1]),
        .wbs_cyc_o(o_cyc[1]), .wbs_stb_o(o_stb[1]), .wbs_adr_o(o_adr[1]), .wbs_we_o(o_we[1]),
        .wbs_dat_o(o_sdat[1]), .wbs_sel_o(o_sel[1]), .wbs_bl_o(o_bl[1]), .wbs_bry_o(o_bry[1]),
        .wbs_dat_i(s_dat[1]), .wbs_ack_i(s_ack[1]), .wbs_lack_i(s_lack[1]), .wbs_err_i(s_err[1])
    );

    // One row per clock cycle on the round-robin instance: master cyc/stb and slave response in, handshake out.
    typedef struct {
        logic [NM-1:0] cyc;
        logic          ack;
        logic          lack;
        logic          err;
        logic          e_stb;
        logic [NM-1:0] e_ack;
        logic [NM-1:0] e_lack;
        logic [NM-1:0] e_err;
    } vec_t;

    vec_t tbl [11];

    // Reference model state: who owns the bus (-1 none), gap pending, last winner, quiet cycles.
    int md_owner[2];
    int md_last [2];
    int md_quiet[2];
    bit md_gap  [2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr(input int d);
        m_cyc[d] = '0; m_stb[d] = '0; m_we[d] = '0; m_bry[d] = '0;
        m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_bl[d] = '0;
        s_dat[d] = '0; s_ack[d] = 1'b0; s_lack[d] = 1'b0; s_err[d] = 1'b0;
    endtask

    function automatic int oh2i(input logic [NM-1:0] v);
        for (int i = 0; i < NM; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pick(input int d, input logic [NM-1:0] req);
        if (d == 1) begin
            for (int i = 0; i < NM; i++) if (req[i]) return i;
            return -1;
        end
        for (int k = 1; k <= NM; k++) if (req[(md_last[d] + k) % NM]) return (md_last[d] + k) % NM;
        return -1;
    endfunction

    task automatic rand_run(input int d, input int cycles, input int ack_pct);
        logic [NM-1:0] e_ack, e_lack, e_err;
        logic          e_cyc, e_bry, gcyc, tfire;
        logic [BL-1:0] b;
        int            o, w;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[d][i]) begin
                    if ($urandom_range(0, 15) == 0) m_cyc[d][i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_cyc[d][i] = 1'b1;
                end
                m_stb[d][i] = m_cyc[d][i] & ($urandom_range(0, 7) != 0);
                m_we[d][i]  = 1'($urandom_range(0, 1));
                m_bry[d][i] = 1'($urandom_range(0, 1));
                m_adr[d][i*AW +: AW] = $urandom;
                m_dat[d][i*DW +: DW] = $urandom;
                m_sel[d][i*BW +: BW] = BW'($urandom);
                m_bl[d][i*BL +: BL]  = BL'($urandom_range(0, 3));
            end
            s_ack[d]  = (int'($urandom_range(0, 99)) < ack_pct);
            s_lack[d] = s_ack[d] && ($urandom_range(0, 3) == 0);
            s_err[d]  = ($urandom_range(0, 59) == 0);
            s_dat[d]  = $urandom;
            @(negedge clk);
            e_ack = '0; e_lack = '0; e_err = '0; e_cyc = 1'b0; e_bry = 1'b0; gcyc = 1'b0; tfire = 1'b0;
            o = md_owner[d];
            if (o >= 0) begin
                gcyc  = m_cyc[d][o];
                tfire = (md_quiet[d] == TOUT - 1) && !s_ack[d] && !s_err[d] && !s_lack[d] && gcyc;
                e_cyc = gcyc;
                e_bry = gcyc & m_bry[d][o];
                if (s_ack[d] && !s_err[d])             e_ack[o]  = 1'b1;
                if (s_lack[d] || s_err[d] || tfire)    e_lack[o] = 1'b1;
                if (s_err[d] || tfire)                 e_err[o]  = 1'b1;
            end
            chk("rnd_ctrl",
                128'({o_cyc[d], o_stb[d], o_bry[d], o_ack[d], o_lack[d], o_err[d], o_mdat[d]}),
                128'({e_cyc, e_cyc, e_bry, e_ack, e_lack, e_err, s_dat[d]}));
            if (o >= 0) begin
                b = m_bl[d][o*BL +: BL];
                if (b == '0) b = 1;
                chk("rnd_data",
                    128'({o_adr[d], o_we[d], o_sdat[d], o_sel[d], o_bl[d]}),
                    128'({m_adr[d][o*AW +: AW], m_we[d][o], m_dat[d][o*DW +: DW], m_sel[d][o*BW +: BW], b}));
                if (s_err[d] || s_lack[d] || !gcyc || tfire) begin
                    md_last[d]  = o;
                    md_owner[d] = -1;
                    md_gap[d]   = 1'b1;
                end else if (s_ack[d]) begin
                    md_quiet[d] = 0;
                end else begin
                    md_quiet[d]++;
                end
            end else if (md_gap[d]) begin
                md_gap[d] = 1'b0;
            end else begin
                w = pick(d, m_cyc[d] & m_stb[d]);
                if (w >= 0) begin
                    md_owner[d] = w;
                    md_quiet[d] = 0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gm[$];
        int gc[$];
        int exp_ord[4];
        int acks, beats, who, m0n, m2n, stbn, nerr, epos;
        logic [2*NM-1:0] errlack;
        logic stb_after, prev_err;

        //            cyc     ack   lack  err   | stb   ack     lack    err
        tbl[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 3'b010, 3'b000};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[6]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 3'b000};
        tbl[8]  = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b100, 3'b100};
        tbl[9]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        tbl[10] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000};
        exp_ord = '{0, 1, 2, 0};

        // Reset state
        rst_n = 1'b0;
        clr(0); clr(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk("reset_outputs", 128'({o_cyc[d], o_stb[d], o_bry[d], o_ack[d], o_lack[d], o_err[d]}), 128'(0));
        rst_n = 1'b1;

        // Single read on M1, then an error on beat 2 of an 8-beat read from M2
        m_adr[0][1*AW +: AW] = 32'h0000_1100;
        m_bl[0][1*BL +: BL]  = BL'(1);
        m_adr[0][2*AW +: AW] = 32'h0000_2200;
        m_bl[0][2*BL +: BL]  = BL'(8);
        for (int r = 0; r < 11; r++) begin
            @(posedge clk); #1;
            m_cyc[0]  = tbl[r].cyc;
            m_stb[0]  = tbl[r].cyc;
            s_ack[0]  = tbl[r].ack;
            s_lack[0] = tbl[r].lack;
            s_err[0]  = tbl[r].err;
            @(negedge clk);
            chk($sformatf("tbl_row%0d", r),
                128'({o_stb[0], o_ack[0], o_lack[0], o_err[0]}),
                128'({tbl[r].e_stb, tbl[r].e_ack, tbl[r].e_lack, tbl[r].e_err}));
        end

        // Round-robin 4-beat writes; M2 joins in the middle of M0's burst
        for (int i = 0; i < NM; i++) begin
            m_adr[0][i*AW +: AW] = 32'h1000 * (i + 1);
            m_bl[0][i*BL +: BL]  = BL'(4);
        end
        m_we[0] = '1;
        acks = 0; beats = 0;
        for (int c = 0; c < 100 && gm.size() < 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_cyc[0] = 3'b011; m_stb[0] = 3'b011; end
            if (c == 2) begin m_cyc[0] = 3'b111; m_stb[0] = 3'b111; end
            #1;
            s_ack[0] = o_stb[0]; s_lack[0] = 1'b0; s_err[0] = 1'b0;
            if (o_stb[0]) begin
                beats++;
                s_lack[0] = (beats == 4);
            end
            @(negedge clk);
            if (o_ack[0] != '0) begin
                acks++;
                who = oh2i(o_ack[0]);
                chk("rr_beat_adr", 128'({o_adr[0], o_we[0], o_bl[0]}), 128'({32'h1000 * (who + 1), 1'b1, BL'(4)}));
            end
            if (o_lack[0] != '0) begin
                gm.push_back(oh2i(o_lack[0]));
                gc.push_back(acks);
                acks = 0; beats = 0;
            end
        end
        chk("rr_burst_budget", 128'(gm.size()), 128'(4));
        for (int k = 0; k < gm.size(); k++) begin
            chk($sformatf("rr_order%0d", k), 128'(gm[k]), 128'(exp_ord[k]));
            chk($sformatf("rr_beats%0d", k), 128'(gc[k]), 128'(4));
        end
        @(posedge clk); #1;
        clr(0);
        repeat (3) @(posedge clk);

        // Fixed priority: M0 keeps re-requesting and starves M2 until it drops
        m0n = 0; m2n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_cyc[1] = 3'b101; m_stb[1] = 3'b101; end
            #1;
            s_ack[1] = o_stb[1]; s_lack[1] = o_stb[1];
            @(negedge clk);
            if (o_lack[1][0]) m0n++;
            if (o_lack[1][2]) m2n++;
        end
        chk("fp_m0_grants", 128'(m0n), 128'(4));
        chk("fp_m2_starved", 128'(m2n), 128'(0));
        m0n = 0; m2n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_cyc[1] = 3'b100; m_stb[1] = 3'b100; end
            #1;
            s_ack[1] = o_stb[1]; s_lack[1] = o_stb[1];
            @(negedge clk);
            if (o_lack[1][0]) m0n++;
            if (o_lack[1][2]) m2n++;
        end
        chk("fp_m2_after_drop", 128'({m0n, m2n}), 128'({32'd0, 32'd2}));
        @(posedge clk); #1;
        clr(1);

        // Timeout: slave never answers M1
        stbn = 0; nerr = 0; epos = -1; errlack = '0; stb_after = 1'b1; prev_err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_cyc[0] = 3'b010; m_stb[0] = 3'b010; end
            @(negedge clk);
            if (prev_err) stb_after = o_stb[0];
            prev_err = 1'b0;
            if (o_stb[0]) stbn++;
            if (o_err[0] != '0) begin
                nerr++;
                prev_err = 1'b1;
                if (epos < 0) begin
                    epos    = stbn;
                    errlack = {o_err[0], o_lack[0]};
                end
            end
        end
        chk("tout_position", 128'(epos), 128'(16));
        chk("tout_errlack", 128'(errlack), 128'({3'b010, 3'b010}));
        chk("tout_one_cycle", 128'(nerr), 128'(1));
        chk("tout_released", 128'(stb_after), 128'(0));
        @(posedge clk); #1;
        clr(0);
        repeat (3) @(posedge clk);

        // Reset in the middle of an 8-beat M0 burst
        m_bl[0][0 +: BL] = BL'(8);
        acks = 0;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m_cyc[0] = 3'b001; m_stb[0] = 3'b001; end
            #1;
            s_ack[0] = o_stb[0];
            @(negedge clk);
            if (o_ack[0][0]) acks++;
        end
        chk("rst_mid_beats", 128'(acks), 128'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 128'({o_cyc[0], o_stb[0], o_bry[0], o_ack[0], o_lack[0], o_err[0]}), 128'(0));
        @(posedge clk); #1;
        s_ack[0] = 1'b0;
        m_cyc[0] = 3'b111; m_stb[0] = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        who = -1;
        for (int c = 0; c < 5 && who < 0; c++) begin
            @(posedge clk); #1;
            #1;
            s_ack[0] = o_stb[0]; s_lack[0] = o_stb[0];
            @(negedge clk);
            if (o_stb[0]) who = oh2i(o_ack[0]);
        end
        chk("rst_first_gnt", 128'(who), 128'(0));

        // Random traffic against the model, on both instances
        @(posedge clk); #1;
        rst_n = 1'b0;
        clr(0); clr(1);
        md_owner = '{-1, -1};
        md_last  = '{NM - 1, NM - 1};
        md_quiet = '{0, 0};
        md_gap   = '{1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        rand_run(0, 600, 60);
        rand_run(0, 300, 4);
        rand_run(1, 600, 60);
        rand_run(1, 300, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
